traffic_phase_scheduler: RTL

Phase scheduler for a four-way intersection with a pedestrian crossing. Three requesters share the intersection: the NS main road (home phase), EW side-road traffic (`car_ew` sensor), and pedestrians (`ped_req` button). The block arbitrates round-robin between EW and pedestrian demand and enforces minimum green, maximum green, yellow and all-red clearance timing. Its registered light outputs drive the lamp drivers directly.

---
 rtl/traffic_phase_scheduler_if.sv | 15 +
 rtl/traffic_phase_scheduler.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/traffic_phase_scheduler_if.sv
// Sensor/button inputs and lamp/debug outputs of the intersection phase scheduler.
// The scheduler takes the slave view; whoever drives the sensors takes the master view.
interface traffic_phase_scheduler_if;
  logic       car_ew;
  logic       ped_req;
  logic [1:0] ns;
  logic [1:0] ew;
  logic       walk;
  logic [2:0] phase;

  modport master (output car_ew, output ped_req,
                  input ns, input ew, input walk, input phase);
  modport slave  (input car_ew, input ped_req,
                  output ns, output ew, output walk, output phase);
endinterface

// File: rtl/traffic_phase_scheduler.sv
// Four-way intersection phase scheduler: NS home green, EW/pedestrian round-robin,
// min/max green, yellow and all-red clearance timing, lamps driven from flops.
module traffic_phase_scheduler #(
  parameter int unsigned MIN_GREEN = 8,
  parameter int unsigned MAX_GREEN = 20,
  parameter int unsigned YELLOW    = 4,
  parameter int unsigned ALL_RED   = 2,
  parameter int unsigned PED_WALK  = 6,
  parameter int unsigned CNT_W     = 8
) (
  input logic                     clock,
  input logic                     clear,
  traffic_phase_scheduler_if.slave bus
);

  localparam logic [2:0] S_NSG  = 3'd0;
  localparam logic [2:0] S_NSY  = 3'd1;
  localparam logic [2:0] S_AR   = 3'd2;
  localparam logic [2:0] S_EWG  = 3'd3;
  localparam logic [2:0] S_EWY  = 3'd4;
  localparam logic [2:0] S_WALK = 3'd5;

  localparam logic [1:0] LAMP_RED = 2'd0;
  localparam logic [1:0] LAMP_YEL = 2'd1;
  localparam logic [1:0] LAMP_GRN = 2'd2;

  localparam logic [CNT_W-1:0] T_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] T_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] T_SAT   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] T_MIN_G = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] T_MAX_G = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] T_YEL   = CNT_W'(YELLOW - 1);
  localparam logic [CNT_W-1:0] T_AR    = CNT_W'(ALL_RED - 1);
  localparam logic [CNT_W-1:0] T_WALK  = CNT_W'(PED_WALK - 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] t_q, t_d;
  logic             ped_pend_q, ped_pend_d;
  logic             rr_q, rr_d;
  logic             from_ns_q, from_ns_d;
  logic [1:0]       ns_q, ns_d;
  logic [1:0]       ew_q, ew_d;
  logic             walk_q, walk_d;
  logic             enter_s;

  // State register; lamps are registered from the next state so they track state_q exactly.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q    <= S_NSG;
      t_q        <= T_ZERO;
      ped_pend_q <= 1'b0;
      rr_q       <= 1'b0;
      from_ns_q  <= 1'b1;
      ns_q       <= LAMP_GRN;
      ew_q       <= LAMP_RED;
      walk_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      t_q        <= t_d;
      ped_pend_q <= ped_pend_d;
      rr_q       <= rr_d;
      from_ns_q  <= from_ns_d;
      ns_q       <= ns_d;
      ew_q       <= ew_d;
      walk_q     <= walk_d;
    end
  end

  // Next-state: every green exits through its yellow and then all-red.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_NSG: begin
        if ((t_q >= T_MIN_G) && (bus.car_ew || ped_pend_q)) state_d = S_NSY;
        else                                                 state_d = S_NSG;
      end
      S_NSY: begin
        if (t_q == T_YEL) state_d = S_AR;
        else              state_d = S_NSY;
      end
      S_AR: begin
        if (t_q != T_AR)                       state_d = S_AR;
        else if (!from_ns_q)                   state_d = S_NSG;
        else if (bus.car_ew && ped_pend_q)     state_d = rr_q ? S_WALK : S_EWG;
        else if (bus.car_ew)                   state_d = S_EWG;
        else if (ped_pend_q)                   state_d = S_WALK;
        else                                   state_d = S_NSG;
      end
      S_EWG: begin
        if ((t_q >= T_MIN_G) && (!bus.car_ew || (t_q == T_MAX_G))) state_d = S_EWY;
        else                                                      state_d = S_EWG;
      end
      S_EWY: begin
        if (t_q == T_YEL) state_d = S_AR;
        else              state_d = S_EWY;
      end
      S_WALK: begin
        if (t_q == T_WALK) state_d = S_AR;
        else               state_d = S_WALK;
      end
      default: state_d = S_NSG;
    endcase
  end

  // Phase timer and the arbitration bookkeeping that rides on state entry.
  always_comb begin
    enter_s = (state_d != state_q);

    if (enter_s)             t_d = T_ZERO;
    else if (t_q == T_SAT)   t_d = t_q;
    else                     t_d = t_q + T_ONE;

    // A press on the same edge that enters WALK stays pending for the next cycle.
    if (bus.ped_req)                          ped_pend_d = 1'b1;
    else if (enter_s && (state_d == S_WALK))  ped_pend_d = 1'b0;
    else                                      ped_pend_d = ped_pend_q;

    if (enter_s && (state_d == S_EWG))        rr_d = 1'b1;
    else if (enter_s && (state_d == S_WALK))  rr_d = 1'b0;
    else                                      rr_d = rr_q;

    if (enter_s && (state_d == S_NSY))                              from_ns_d = 1'b1;
    else if (enter_s && ((state_d == S_EWY) || (state_d == S_WALK))) from_ns_d = 1'b0;
    else                                                            from_ns_d = from_ns_q;
  end

  // Lamp decode of the upcoming state.
  always_comb begin
    ns_d   = LAMP_RED;
    ew_d   = LAMP_RED;
    walk_d = 1'b0;
    case (state_d)
      S_NSG:   ns_d   = LAMP_GRN;
      S_NSY:   ns_d   = LAMP_YEL;
      S_AR:    ns_d   = LAMP_RED;
      S_EWG:   ew_d   = LAMP_GRN;
      S_EWY:   ew_d   = LAMP_YEL;
      S_WALK:  walk_d = 1'b1;
      default: ns_d   = LAMP_GRN;
    endcase
  end

  assign bus.ns    = ns_q;
  assign bus.ew    = ew_q;
  assign bus.walk  = walk_q;
  assign bus.phase = state_q;

endmodule
